// File: rtl/muldiv_pkg.sv
// Shared types for the multiply issue path.
//   mul_op_t    : multiply opcode as carried from dispatch to the multiplier
//   mul_entry_t : one queued micro-op (operands, opcode, ROB tag) at the
//                 default tag width; blocks with a different TAG_W rebuild
//                 the same layout locally
//   iq_state_t  : issue-queue sequencer state
package muldiv_pkg;

  localparam int XLEN      = 32;
  localparam int DEF_TAG_W = 6;

  typedef enum logic [1:0] {
    MUL    = 2'b00,
    MULH   = 2'b01,
    MULHSU = 2'b10,
    MULHU  = 2'b11
  } mul_op_t;

  typedef struct packed {
    logic [XLEN-1:0]      a;
    logic [XLEN-1:0]      b;
    mul_op_t              op;
    logic [DEF_TAG_W-1:0] tag;
  } mul_entry_t;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } iq_state_t;

endpackage

// File: rtl/mul_op_fifo.sv
// In-order synchronous FIFO of multiply micro-ops.
//   clk_i, rst_i : clock, synchronous active-high reset
//   push, wdata  : write wdata at the tail (caller guarantees not full)
//   pop          : advance the head (caller guarantees not empty)
//   flush        : empty the FIFO; overrides push and pop
//   head         : entry at the head, valid whenever count != 0
//   count        : number of stored entries, 0..DEPTH
module mul_op_fifo
  import muldiv_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = mul_entry_t,
  localparam int AW      = $clog2(DEPTH),
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push,
  input  entry_t        wdata,
  input  logic          pop,
  input  logic          flush,
  output entry_t        head,
  output logic [CW-1:0] count
);

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage is not reset; slots are only read after being written.
  always_ff @(posedge clk_i) begin
    if (push && !flush && !rst_i) mem[wr_ptr] <= wdata;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/mul_issue_queue.sv
// Issue queue in front of the integer multiplier.
// Buffers multiply micro-ops from dispatch, issues them one at a time to a
// multiplier that allows a single op in flight, and pairs each returned
// result with the saved ROB tag to form a writeback. A flush empties the
// queue and marks any in-flight op as killed; since the multiplier cannot be
// cancelled, the sequencer still waits for that result and then drops it.
//   clk_i, rst_i          : clock, synchronous active-high reset
//   enq_*                 : dispatch handshake and op fields
//   flush_i               : kill all queued and in-flight ops
//   mul_valid_o, mul_*_o  : one-cycle issue pulse and registered operands
//   mul_vld_i, mul_result_i : result pulse from the multiplier
//   wb_valid_o, wb_tag_o, wb_data_o : one-cycle writeback
//   busy_o                : queue non-empty or op in flight
module mul_issue_queue
  import muldiv_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enq_valid_i,
  output logic             enq_ready_o,
  input  logic [XLEN-1:0]  enq_a_i,
  input  logic [XLEN-1:0]  enq_b_i,
  input  logic [1:0]       enq_op_i,
  input  logic [TAG_W-1:0] enq_tag_i,
  input  logic             flush_i,
  output logic             mul_valid_o,
  output logic [XLEN-1:0]  mul_a_o,
  output logic [XLEN-1:0]  mul_b_o,
  output logic [1:0]       mul_op_o,
  input  logic             mul_vld_i,
  input  logic [XLEN-1:0]  mul_result_i,
  output logic             wb_valid_o,
  output logic [TAG_W-1:0] wb_tag_o,
  output logic [XLEN-1:0]  wb_data_o,
  output logic             busy_o
);

  localparam int            CW   = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // Same layout as mul_entry_t, with the tag sized by this instance.
  typedef struct packed {
    logic [XLEN-1:0]  a;
    logic [XLEN-1:0]  b;
    mul_op_t          op;
    logic [TAG_W-1:0] tag;
  } iq_entry_t;

  iq_state_t        state;
  logic             kill;
  logic [TAG_W-1:0] inflight_tag;
  iq_entry_t        enq_ent;
  iq_entry_t        head;
  logic [CW-1:0]    count;
  logic             push;
  logic             pop;

  // No bypass when full: a pop in the same cycle does not open a slot.
  assign enq_ready_o = (count != FULL) && !flush_i;
  assign push        = enq_valid_i && enq_ready_o;
  assign pop         = (state == IDLE) && (count != '0) && !flush_i;
  assign busy_o      = (count != '0) || (state == WAIT);

  assign enq_ent = '{a: enq_a_i, b: enq_b_i, op: mul_op_t'(enq_op_i), tag: enq_tag_i};

  mul_op_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (iq_entry_t)
  ) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (push),
    .wdata (enq_ent),
    .pop   (pop),
    .flush (flush_i),
    .head  (head),
    .count (count)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      kill         <= 1'b0;
      inflight_tag <= '0;
      mul_valid_o  <= 1'b0;
      mul_a_o      <= '0;
      mul_b_o      <= '0;
      mul_op_o     <= '0;
      wb_valid_o   <= 1'b0;
      wb_tag_o     <= '0;
      wb_data_o    <= '0;
    end else begin
      mul_valid_o <= 1'b0;
      wb_valid_o  <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            mul_valid_o  <= 1'b1;
            mul_a_o      <= head.a;
            mul_b_o      <= head.b;
            mul_op_o     <= head.op;
            inflight_tag <= head.tag;
            state        <= WAIT;
          end
        end
        WAIT: begin
          if (mul_vld_i) begin
            // A flush arriving with the result kills it just like an
            // earlier flush would have.
            if (!kill && !flush_i) begin
              wb_valid_o <= 1'b1;
              wb_tag_o   <= inflight_tag;
              wb_data_o  <= mul_result_i;
            end
            kill  <= 1'b0;
            state <= IDLE;
          end else if (flush_i) begin
            kill <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A result with nothing outstanding means the multiplier and this queue
  // disagree about what is in flight.
  a_no_stray_result: assert property (@(posedge clk_i) disable iff (rst_i)
    !(mul_vld_i && state == IDLE));

  a_issue_one_cycle: assert property (@(posedge clk_i) disable iff (rst_i)
    mul_valid_o |=> !mul_valid_o);

endmodule

// File: tb/tb_mul_issue_queue.sv
// Self-checking bench for mul_issue_queue: a multiplier model answers each
// issue after a programmable latency (or holds it while stalled), and a
// queue-level reference model predicts every output each cycle.
module tb_mul_issue_queue;

  localparam int DEPTH = 4;
  localparam int TAG_W = 6;
  localparam int NC    = 4096;

  logic             clk = 1'b0;
  logic             rst_i = 1'b1;
  logic             enq_valid_i = 1'b0;
  logic             enq_ready_o;
  logic [31:0]      enq_a_i = '0;
  logic [31:0]      enq_b_i = '0;
  logic [1:0]       enq_op_i = '0;
  logic [TAG_W-1:0] enq_tag_i = '0;
  logic             flush_i = 1'b0;
  logic             mul_valid_o;
  logic [31:0]      mul_a_o;
  logic [31:0]      mul_b_o;
  logic [1:0]       mul_op_o;
  logic             mul_vld_i = 1'b0;
  logic [31:0]      mul_result_i = '0;
  logic             wb_valid_o;
  logic [TAG_W-1:0] wb_tag_o;
  logic [31:0]      wb_data_o;
  logic             busy_o;

  mul_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .enq_valid_i  (enq_valid_i),
    .enq_ready_o  (enq_ready_o),
    .enq_a_i      (enq_a_i),
    .enq_b_i      (enq_b_i),
    .enq_op_i     (enq_op_i),
    .enq_tag_i    (enq_tag_i),
    .flush_i      (flush_i),
    .mul_valid_o  (mul_valid_o),
    .mul_a_o      (mul_a_o),
    .mul_b_o      (mul_b_o),
    .mul_op_o     (mul_op_o),
    .mul_vld_i    (mul_vld_i),
    .mul_result_i (mul_result_i),
    .wb_valid_o   (wb_valid_o),
    .wb_tag_o     (wb_tag_o),
    .wb_data_o    (wb_data_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]      a;
    logic [31:0]      b;
    logic [1:0]       op;
    logic [TAG_W-1:0] tag;
  } ent_t;

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
    int               c;
  } wb_t;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;

  // reference model
  ent_t mq[$];
  bit   m_inf = 0, m_kill = 0, exp_mv = 0, exp_wv = 0;
  ent_t cur_ent, iss_ent, wb_ent;

  // multiplier model
  bit          m_busy = 0, mstall = 0, mrand = 0;
  int          m_cnt = 0, mlat = 3;
  logic [31:0] m_res = '0;

  // per-cycle logs for literal checks
  bit               mv_at [NC];
  bit               wv_at [NC];
  bit               busy_at [NC];
  bit               ready_at [NC];
  bit               vld_at [NC];
  logic [31:0]      ia_at [NC];
  logic [31:0]      ib_at [NC];
  logic [1:0]       iop_at [NC];
  logic [TAG_W-1:0] wtag_at [NC];
  logic [31:0]      wdata_at [NC];
  wb_t              wlog[$];

  function automatic logic [31:0] mulfunc(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] op);
    logic [63:0] ea, eb, p;
    ea = (op == 2'b01 || op == 2'b10) ? {{32{a[31]}}, a} : {32'b0, a};
    eb = (op == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
    p  = ea * eb;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic step(input bit ev, input logic [31:0] a, input logic [31:0] b,
                      input logic [1:0] op, input logic [TAG_W-1:0] tag,
                      input bit fl, input bit rs);
    bit   old_inf, nmv, nwv, can_enq, vld;
    ent_t e;
    @(posedge clk);
    #1;
    cyc++;
    mv_at[cyc] = mul_valid_o;  wv_at[cyc] = wb_valid_o;
    ia_at[cyc] = mul_a_o;      ib_at[cyc] = mul_b_o;    iop_at[cyc] = mul_op_o;
    wtag_at[cyc] = wb_tag_o;   wdata_at[cyc] = wb_data_o;
    chk("mul_valid", 64'(mul_valid_o), 64'(exp_mv));
    if (exp_mv) begin
      chk("mul_a", 64'(mul_a_o), 64'(iss_ent.a));
      chk("mul_b", 64'(mul_b_o), 64'(iss_ent.b));
      chk("mul_op", 64'(mul_op_o), 64'(iss_ent.op));
    end
    chk("wb_valid", 64'(wb_valid_o), 64'(exp_wv));
    if (exp_wv) begin
      chk("wb_tag", 64'(wb_tag_o), 64'(wb_ent.tag));
      chk("wb_data", 64'(wb_data_o), 64'(mulfunc(wb_ent.a, wb_ent.b, wb_ent.op)));
    end
    if (wb_valid_o === 1'b1) wlog.push_back('{tag: wb_tag_o, data: wb_data_o, c: cyc});

    // multiplier: accept issue, answer after latency unless stalled
    if (mul_valid_o === 1'b1) begin
      chk("mult_free_at_issue", 64'(m_busy), 64'(0));
      m_busy = 1;
      m_res  = mulfunc(mul_a_o, mul_b_o, mul_op_o);
      m_cnt  = mrand ? int'($urandom_range(5, 1)) : mlat;
    end
    vld = 0;
    if (m_busy) begin
      if (m_cnt == 0) begin
        if (!mstall) begin vld = 1; m_busy = 0; end
      end else m_cnt--;
    end
    vld_at[cyc]  = vld;
    mul_vld_i    = vld;
    mul_result_i = vld ? m_res : $urandom;
    enq_valid_i = ev; enq_a_i = a; enq_b_i = b; enq_op_i = op; enq_tag_i = tag;
    flush_i = fl; rst_i = rs;
    #1;
    ready_at[cyc] = enq_ready_o;
    busy_at[cyc]  = busy_o;
    chk("enq_ready", 64'(enq_ready_o), 64'((mq.size() != DEPTH) && !fl));
    chk("busy", 64'(busy_o), 64'((mq.size() != 0) || m_inf));

    // reference model advances to the next cycle
    if (rs) begin
      mq.delete(); m_inf = 0; m_kill = 0; exp_mv = 0; exp_wv = 0; m_busy = 0;
    end else begin
      old_inf = m_inf; nmv = 0; nwv = 0;
      can_enq = ev && (mq.size() != DEPTH) && !fl;
      if (old_inf) begin
        if (vld) begin
          if (!m_kill && !fl) begin nwv = 1; wb_ent = cur_ent; end
          m_inf = 0; m_kill = 0;
        end else if (fl) m_kill = 1;
      end else if (mq.size() != 0 && !fl) begin
        cur_ent = mq.pop_front(); iss_ent = cur_ent; nmv = 1; m_inf = 1;
      end
      if (fl) mq.delete();
      else if (can_enq) begin
        e.a = a; e.b = b; e.op = op; e.tag = tag;
        mq.push_back(e);
      end
      exp_mv = nmv; exp_wv = nwv;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, '0, '0, '0, 0, 0);
  endtask

  task automatic enq(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                     input logic [TAG_W-1:0] tag);
    step(1, a, b, op, tag, 0, 0);
  endtask

  function automatic int tag_hits(input int from, input logic [TAG_W-1:0] lo,
                                  input logic [TAG_W-1:0] hi);
    int n = 0;
    for (int i = from; i < wlog.size(); i++)
      if (wlog[i].tag >= lo && wlog[i].tag <= hi) n++;
    return n;
  endfunction

  function automatic logic [31:0] rnd_opnd();
    case ($urandom % 5)
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'(int'($urandom % 16));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int t, w0;
    // reset
    step(0, '0, '0, '0, '0, 0, 1);
    step(0, '0, '0, '0, '0, 0, 1);
    idle(2);
    chk("rst_busy", 64'(busy_at[cyc]), 64'(0));
    chk("rst_ready", 64'(ready_at[cyc]), 64'(1));
    chk("rst_mul_valid", 64'(mv_at[cyc]), 64'(0));

    // single op 7*6, tag 5, latency 3
    mlat = 3; mrand = 0; mstall = 0;
    t = cyc + 1;
    enq(32'd7, 32'd6, 2'b00, 6'd5);
    idle(8);
    chk("t1_no_early_issue", 64'(mv_at[t+1]), 64'(0));
    chk("t1_issue_cyc2", 64'(mv_at[t+2]), 64'(1));
    chk("t1_issue_a", 64'(ia_at[t+2]), 64'(7));
    chk("t1_issue_b", 64'(ib_at[t+2]), 64'(6));
    chk("t1_issue_op", 64'(iop_at[t+2]), 64'(0));
    chk("t1_wb_cyc6", 64'(wv_at[t+6]), 64'(1));
    chk("t1_wb_tag", 64'(wtag_at[t+6]), 64'(5));
    chk("t1_wb_data", 64'(wdata_at[t+6]), 64'(42));
    chk("t1_idle_cyc7", 64'(busy_at[t+7]), 64'(0));

    // stalled multiplier, six offers, queue fills at tag 6
    mstall = 1;
    w0 = wlog.size();
    t = cyc + 1;
    for (int i = 1; i <= 6; i++) enq(32'(i * 3), 32'(i + 1), 2'(i % 4), TAG_W'(i));
    idle(6);
    chk("t2_full_at_tag6", 64'(ready_at[t+5]), 64'(0));
    chk("t2_ready_before", 64'(ready_at[t+4]), 64'(1));
    mstall = 0;
    idle(40);
    chk("t2_wb_count", 64'(wlog.size() - w0), 64'(5));
    for (int k = 0; k < 5 && w0 + k < wlog.size(); k++) begin
      chk("t2_wb_order", 64'(wlog[w0+k].tag), 64'(k + 1));
      if (k > 0) chk("t2_wb_gap_ge4", 64'((wlog[w0+k].c - wlog[w0+k-1].c) >= 4), 64'(1));
    end

    // flush in the cycle after issue with two ops queued
    w0 = wlog.size();
    t = cyc + 1;
    enq(32'd3, 32'd4, 2'b00, 6'd20);
    enq(32'd5, 32'd6, 2'b00, 6'd21);
    enq(32'd8, 32'd9, 2'b00, 6'd22);
    step(0, '0, '0, '0, '0, 1, 0);
    idle(10);
    chk("t3_issue_before_flush", 64'(mv_at[t+2]), 64'(1));
    chk("t3_busy_while_killed", 64'(busy_at[t+4]), 64'(1));
    chk("t3_idle_after_drop", 64'(busy_at[t+6]), 64'(0));
    enq(32'd11, 32'd12, 2'b00, 6'd9);
    idle(10);
    chk("t3_no_killed_wb", 64'(tag_hits(w0, 6'd20, 6'd22)), 64'(0));
    chk("t3_tag9_wb", 64'(tag_hits(w0, 6'd9, 6'd9)), 64'(1));

    // flush coincident with the result pulse
    w0 = wlog.size();
    t = cyc + 1;
    enq(32'd2, 32'd2, 2'b11, 6'd30);
    idle(4);
    step(0, '0, '0, '0, '0, 1, 0);
    idle(5);
    chk("t4_vld_at_flush", 64'(vld_at[t+5]), 64'(1));
    chk("t4_wb_suppressed", 64'(wv_at[t+6]), 64'(0));
    chk("t4_idle_next", 64'(busy_at[t+6]), 64'(0));
    chk("t4_no_wb30", 64'(tag_hits(w0, 6'd30, 6'd30)), 64'(0));

    // reset while waiting with three queued
    mstall = 1;
    w0 = wlog.size();
    t = cyc + 1;
    for (int i = 0; i < 4; i++) enq(32'(100 + i), 32'd3, 2'b01, TAG_W'(40 + i));
    idle(1);
    step(0, '0, '0, '0, '0, 0, 1);
    mstall = 0;
    idle(8);
    chk("t5_busy_pre", 64'(busy_at[t+5]), 64'(1));
    chk("t5_busy", 64'(busy_at[t+6]), 64'(0));
    chk("t5_ready", 64'(ready_at[t+6]), 64'(1));
    chk("t5_mul_valid", 64'(mv_at[t+6]), 64'(0));
    chk("t5_wb_valid", 64'(wv_at[t+6]), 64'(0));
    chk("t5_no_wb", 64'(tag_hits(w0, 6'd40, 6'd43)), 64'(0));

    // enqueue and flush together
    w0 = wlog.size();
    t = cyc + 1;
    step(1, 32'd5, 32'd5, 2'b00, 6'd50, 1, 0);
    idle(8);
    chk("t6_ready_low", 64'(ready_at[t]), 64'(0));
    chk("t6_not_stored", 64'(busy_at[t+1]), 64'(0));
    chk("t6_no_issue", 64'(mv_at[t+2]), 64'(0));
    chk("t6_no_wb", 64'(tag_hits(w0, 6'd50, 6'd50)), 64'(0));

    // randomized traffic
    mrand = 1;
    for (int i = 0; i < 1500; i++) begin
      mstall = ($urandom % 100) < 10;
      step(($urandom % 100) < 60, rnd_opnd(), rnd_opnd(), 2'($urandom % 4),
           TAG_W'($urandom), ($urandom % 100) < 4, ($urandom % 1000) < 5);
    end
    mstall = 0;
    idle(30);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
